// File: rtl/div_pkg.sv
// div_pkg
// Shared constants for the multi-cycle divider: bus widths, FSM state
// encodings, ready/start levels and a small magnitude helper used when
// latching signed operands.
package div_pkg;

  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;

  localparam logic [1:0] DivFree   = 2'b00;
  localparam logic [1:0] DivByZero = 2'b01;
  localparam logic [1:0] DivOn     = 2'b10;
  localparam logic [1:0] DivEnd    = 2'b11;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  // Two's complement magnitude when the operand is treated as signed.
  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [RegBus-1:0] abs_val(input logic [RegBus-1:0] v,
                                                input logic is_signed);
    return (is_signed && v[RegBus-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div.sv
// div
// Radix-2 restoring divider for MIPS DIV/DIVU, one quotient bit per cycle.
// Ports:
//   clk, rst       : clock and synchronous active-high reset
//   signed_div_i   : 1 = signed (DIV), 0 = unsigned (DIVU)
//   opdata1_i      : dividend, sampled only when a start is accepted
//   opdata2_i      : divisor, sampled only when a start is accepted
//   start_i        : request, held high until ready_o is seen
//   annul_i        : abort an operation in progress
//   result_o       : {remainder (HI), quotient (LO)}
//   ready_o        : result valid
module div
  import div_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    signed_div_i,
  input  logic [RegBus-1:0]       opdata1_i,
  input  logic [RegBus-1:0]       opdata2_i,
  input  logic                    start_i,
  input  logic                    annul_i,
  output logic [DoubleRegBus-1:0] result_o,
  output logic                    ready_o
);

  logic [1:0]              state_q, state_d;
  logic [5:0]              cnt_q, cnt_d;
  logic [64:0]             working_q, working_d;
  logic [RegBus-1:0]       divisor_q, divisor_d;
  logic                    neg_quot_q, neg_quot_d;
  logic                    neg_rem_q, neg_rem_d;
  logic [DoubleRegBus-1:0] result_q, result_d;
  logic                    ready_q, ready_d;

  logic [RegBus-1:0] op1_abs;
  logic [RegBus-1:0] op2_abs;
  logic [32:0]       partial;
  logic              trial_ge;
  logic [RegBus-1:0] trial_diff;
  logic [RegBus-1:0] quot_fix;
  logic [RegBus-1:0] rem_fix;

  assign op1_abs = abs_val(opdata1_i, signed_div_i);
  assign op2_abs = abs_val(opdata2_i, signed_div_i);

  // The partial remainder plus the next dividend bit can need 33 bits when
  // the divisor is close to 2^32, so the compare is done on all 33 bits.
  // When it succeeds the true difference is below the divisor and fits in
  // 32 bits, so a 32-bit modulo subtract gives it exactly.
  assign partial    = working_q[64:32];
  assign trial_ge   = (partial >= {1'b0, divisor_q});
  assign trial_diff = partial[31:0] - divisor_q;

  // Sign fix-up: quotient follows the XOR of operand signs, remainder
  // follows the dividend sign (truncating division).
  assign quot_fix = neg_quot_q ? (~working_q[31:0] + 1'b1) : working_q[31:0];
  assign rem_fix  = neg_rem_q ? (~working_q[64:33] + 1'b1) : working_q[64:33];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    working_d  = working_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;

    case (state_q)
      DivFree: begin
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DivByZero;
          end else begin
            state_d    = DivOn;
            cnt_d      = 6'd0;
            working_d  = {32'b0, op1_abs, 1'b0};
            divisor_d  = op2_abs;
            neg_quot_d = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
            neg_rem_d  = signed_div_i & opdata1_i[31];
          end
        end
      end

      DivByZero: begin
        state_d  = DivEnd;
        result_d = '0;
        ready_d  = DivResultReady;
      end

      DivOn: begin
        if (annul_i) begin
          state_d  = DivFree;
          result_d = '0;
          ready_d  = DivResultNotReady;
        end else if (cnt_q != 6'd32) begin
          if (trial_ge) begin
            working_d = {trial_diff, working_q[31:0], 1'b1};
          end else begin
            working_d = {working_q[63:0], 1'b0};
          end
          cnt_d = cnt_q + 6'd1;
        end else begin
          state_d  = DivEnd;
          result_d = {rem_fix, quot_fix};
          ready_d  = DivResultReady;
        end
      end

      default: begin
        if (start_i == DivStop) begin
          state_d  = DivFree;
          result_d = '0;
          ready_d  = DivResultNotReady;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DivFree;
      cnt_q      <= '0;
      working_q  <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= DivResultNotReady;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      working_q  <= working_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// tb_div
// Directed bench for the divider: a transaction-level reference model
// (plain integer division plus a latency countdown) is checked against the
// DUT outputs every cycle, and each directed case also checks hand-computed
// latency and result literals.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int tests_run    = 0;
  int tests_failed = 0;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  // Reference arithmetic: 64-bit integer division avoids the
  // most-negative / -1 overflow, then the results wrap to 32 bits.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Transaction model: idle -> busy (33 edges, or 1 for a zero divisor)
  // -> done, held while start stays high.
  int          m_phase = 0;
  int          m_remaining = 0;
  bit          m_dz = 1'b0;
  logic [63:0] m_pending = '0;
  logic [63:0] m_result = '0;
  logic        m_ready = 1'b0;
  bit          model_on = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase  = 0;
      m_ready  = 1'b0;
      m_result = '0;
    end else begin
      case (m_phase)
        0: if (start_i && !annul_i) begin
          m_dz        = (opdata2_i == 32'd0);
          m_remaining = m_dz ? 1 : 33;
          m_pending   = ref_div(signed_div_i, opdata1_i, opdata2_i);
          m_phase     = 1;
        end
        1: if (!m_dz && annul_i) begin
          m_phase  = 0;
          m_ready  = 1'b0;
          m_result = '0;
        end else begin
          m_remaining--;
          if (m_remaining == 0) begin
            m_ready  = 1'b1;
            m_result = m_pending;
            m_phase  = 2;
          end
        end
        default: if (!start_i) begin
          m_phase  = 0;
          m_ready  = 1'b0;
          m_result = '0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      tests_run++;
      if (ready_o !== m_ready) begin
        tests_failed++;
        $display("[TB] FAIL cycle_ready at %0t: got %b expected %b", $time, ready_o, m_ready);
      end
      tests_run++;
      if (result_o !== m_result) begin
        tests_failed++;
        $display("[TB] FAIL cycle_result at %0t: got %h expected %h", $time, result_o, m_result);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Called at a negedge: presents operands and start, scrambles the operands
  // after the accepting edge, and counts edges until ready_o is seen.
  task automatic applyStimulus(input logic s, input logic [31:0] a,
                               input logic [31:0] b, output int lat);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    lat          = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
      end
      if (ready_o === 1'b1) break;
    end
    if (ready_o !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL ready_timeout: got %0d cycles without ready expected ready", lat);
    end
  endtask

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int lat;
    int rose;

    vecs[0] = '{1'b0, 32'd7,         32'd2,         {32'h00000001, 32'h00000003}};
    vecs[1] = '{1'b1, 32'hFFFFFFF9, 32'd2,         {32'hFFFFFFFF, 32'hFFFFFFFD}};
    vecs[2] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}};
    vecs[3] = '{1'b0, 32'hFFFFFFFF, 32'd1,         {32'h00000000, 32'hFFFFFFFF}};
    vecs[4] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE, {32'h00000001, 32'h00000001}};
    vecs[5] = '{1'b1, 32'd7,         32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}};
    vecs[6] = '{1'b0, 32'hFFFFFFFE, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000000}};

    rst          = 1'b1;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    model_on     = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("reset_ready", {63'b0, ready_o}, 64'd0);
    checkOutput("reset_result", result_o, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].s, vecs[i].a, vecs[i].b, lat);
      checkOutput($sformatf("vec%0d_latency", i), 64'(lat), 64'd34);
      checkOutput($sformatf("vec%0d_result", i), result_o, vecs[i].exp);
      start_i = 1'b0;
      @(negedge clk);
      checkOutput($sformatf("vec%0d_drop_ready", i), {63'b0, ready_o}, 64'd0);
    end

    applyStimulus(1'b0, 32'd1234, 32'd0, lat);
    checkOutput("dz_latency", 64'(lat), 64'd2);
    checkOutput("dz_result", result_o, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("dz_hold_ready", {63'b0, ready_o}, 64'd1);
      checkOutput("dz_hold_result", result_o, 64'd0);
    end
    start_i = 1'b0;
    @(negedge clk);
    checkOutput("dz_drop_ready", {63'b0, ready_o}, 64'd0);

    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    rose         = 0;
    repeat (11) begin
      @(negedge clk);
      if (ready_o === 1'b1) rose = 1;
    end
    annul_i = 1'b1;
    @(negedge clk);
    checkOutput("annul_ready", {63'b0, ready_o}, 64'd0);
    checkOutput("annul_result", result_o, 64'd0);
    checkOutput("annul_never_ready", 64'(rose), 64'd0);
    annul_i = 1'b0;
    applyStimulus(1'b0, 32'd100, 32'd7, lat);
    checkOutput("restart_latency", 64'(lat), 64'd34);
    checkOutput("restart_result", result_o, {32'd2, 32'd14});
    start_i = 1'b0;
    @(negedge clk);

    signed_div_i = 1'b1;
    opdata1_i    = 32'd12345;
    opdata2_i    = 32'd67;
    start_i      = 1'b1;
    repeat (21) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_ready", {63'b0, ready_o}, 64'd0);
    checkOutput("rst_mid_result", result_o, 64'd0);
    rst     = 1'b0;
    start_i = 1'b0;
    rose    = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o === 1'b1) rose = 1;
    end
    checkOutput("rst_no_resume", 64'(rose), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
